// File: rtl/mem_byte_packer_if.sv
// Byte-stream write sequencer bus bundle: command, byte stream and RAM write port.
interface mem_byte_packer_if #(
  parameter int ADDR_W = 8
);
  logic                start;
  logic [ADDR_W+1:0]   base_addr;
  logic [ADDR_W+2:0]   length;
  logic                busy;
  logic                done;
  logic                s_valid;
  logic [7:0]          s_data;
  logic                s_ready;
  logic                wren;
  logic [ADDR_W-1:0]   wraddress;
  logic [3:0]          byteena_a;
  logic [31:0]         data;

  // Master issues commands and bytes and observes the RAM write port.
  modport master (
    output start, base_addr, length, s_valid, s_data,
    input  busy, done, s_ready, wren, wraddress, byteena_a, data
  );

  // Slave is the packer itself.
  modport slave (
    input  start, base_addr, length, s_valid, s_data,
    output busy, done, s_ready, wren, wraddress, byteena_a, data
  );
endinterface

// File: rtl/mem_byte_packer.sv
// Packs a byte stream into byte-enabled 32-bit word writes for the 256x32 RAMs.
// A word is flushed on lane 3 or on the last byte; flush and the next byte
// acceptance share a cycle so the stream never stalls.
module mem_byte_packer #(
  parameter int ADDR_W = 8
) (
  input logic                clk,
  input logic                rst,
  mem_byte_packer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W+1:0]   ptr_q, ptr_d;
  logic [ADDR_W+2:0]   rem_q, rem_d;
  logic [31:0]         accData_q, accData_d;
  logic [3:0]          accBe_q, accBe_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   wrAddr_q, wrAddr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         data_q, data_d;

  logic                accept;
  logic                lastByte;
  logic [31:0]         mergedData;
  logic [3:0]          mergedBe;

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.s_ready   = (state_q == RUN) && (rem_q != '0);
  assign bus.wren      = wren_q;
  assign bus.wraddress = wrAddr_q;
  assign bus.byteena_a = be_q;
  assign bus.data      = data_q;

  assign accept   = bus.s_valid && bus.s_ready;
  assign lastByte = (rem_q == (ADDR_W+3)'(1));

  // Accumulator with the incoming byte dropped into its lane.
  always_comb begin
    mergedData = accData_q;
    mergedData[{ptr_q[1:0], 3'b000} +: 8] = bus.s_data;
    mergedBe = accBe_q | (4'b0001 << ptr_q[1:0]);
  end

  // Next state, byte pointer bookkeeping and registered write-port contents.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    accData_d = accData_q;
    accBe_d   = accBe_q;
    wren_d    = 1'b0;
    wrAddr_d  = '0;
    be_d      = '0;
    data_d    = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            ptr_d     = bus.base_addr;
            rem_d     = bus.length;
            accData_d = '0;
            accBe_d   = '0;
            state_d   = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (accept) begin
          ptr_d = ptr_q + (ADDR_W+2)'(1);
          rem_d = rem_q - (ADDR_W+3)'(1);
          if ((ptr_q[1:0] == 2'd3) || lastByte) begin
            wren_d    = 1'b1;
            wrAddr_d  = ptr_q[ADDR_W+1:2];
            be_d      = mergedBe;
            data_d    = mergedData;
            accData_d = '0;
            accBe_d   = '0;
          end else begin
            accData_d = mergedData;
            accBe_d   = mergedBe;
          end
          if (lastByte) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and write-port registers; reset discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      accData_q <= '0;
      accBe_q   <= '0;
      wren_q    <= 1'b0;
      wrAddr_q  <= '0;
      be_q      <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      accData_q <= accData_d;
      accBe_q   <= accBe_d;
      wren_q    <= wren_d;
      wrAddr_q  <= wrAddr_d;
      be_q      <= be_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: doc/mem_byte_packer.md
# mem_byte_packer

Byte-stream write sequencer for the 256x32 byte-enabled video/palette RAMs. Accepts a stream of bytes over a valid/ready handshake, places each byte in its lane by byte address, and issues 32-bit word writes with byte enables on the RAM write port. It is the filling end of the RAM whose read side returns 8-bit data from a 10-bit byte address. Used by the ROM/SDRAM loader and CPU-side copy paths.

## Interface
- ADDR_W, 8, word address width; the byte address is ADDR_W+2 bits
- rst  in  1  reset, asynchronous, active-high
- clk  in  1  single clock; the RAM write clock is tied to it
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W+2  first byte address, latched on start
- length  in  ADDR_W+3  byte count, 0..1024, latched on start
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of transfer
- s_valid  in  1  byte available
- s_data  in  8  byte value
- s_ready  out  1  byte accepted when s_valid & s_ready
- wren  out  1  word write strobe
- wraddress  out  ADDR_W  word address
- byteena_a  out  4  lane enables; bit k = data[8k+7:8k]
- data  out  32  packed word; non-enabled lanes are 0

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1, length≠0: latch byte pointer=base_addr and remaining=length, clear the accumulator, then go to RUN.
- IDLE, start=1, length=0: go to DONE. No write occurs.
- start outside IDLE is ignored.
- RUN: s_ready = (remaining≠0).
- On each accepted byte:
  - lane = pointer[1:0].
  - The accumulator lane gets s_data and its enable bit is set.
  - pointer increments modulo 2^(ADDR_W+2); 0x3FF wraps to 0x000.
  - remaining decrements.
- A word is flushed when the accepted byte is in lane 3, or is the last byte (remaining becomes 0).
- Flush, registered for the next cycle:
  - wren=1.
  - wraddress = the pre-increment pointer[ADDR_W+1:2].
  - byteena_a and data come from the accumulator.
  - The accumulator is then cleared.
- A flush and the next byte acceptance occur in the same cycle. Sustained throughput is 1 byte/cycle with no stall.
- When the last byte is accepted, the state goes to DONE. DONE lasts one cycle, pulses done, then returns to IDLE.
- Reset, including mid-transfer: the state goes to IDLE immediately, with no flush. A partial word is discarded.
- Reset values of outputs: busy=0, done=0, s_ready=0, wren=0, wraddress=0, byteena_a=0, data=0.

## Timing
- start sampled at cycle 0: busy=1 and s_ready=1 from cycle 1.
- Byte accepted at cycle n that triggers a flush: wren=1 in cycle n+1 only.
- Last byte accepted at cycle n:
  - s_ready=0 from cycle n+1.
  - The final wren and done are both high in cycle n+1.
  - busy=0 from cycle n+2.
  - A new start is accepted from cycle n+2.
- length=0, start at cycle 0: done=1 in cycle 1, busy=0 in cycle 2.
- wren, wraddress, byteena_a and data are registered.
  - wraddress, byteena_a and data are 0 in any cycle where wren=0.
  - s_ready is decoded from registered state only, with no combinational path from s_valid.
- Gaps in s_valid create no writes and no state change. Packing is independent of when bytes arrive.

## Test plan
- Aligned transfer: base 0x000, length 4, bytes 11 22 33 44 back-to-back -> one write: wraddress 0x00, byteena_a F, data 0x44332211; done with it; 4 bytes accepted in 4 cycles.
- Unaligned transfer: base 0x003, length 3, bytes AA BB CC -> first write: addr 0x00, be 8, data 0xAA000000. Second write: addr 0x01, be 3, data 0x0000CCBB, with done.
- Wrap-around with backpressure: base 0x3FE, length 4, s_valid toggling 1/0 -> first write: addr 0xFF, be C. Second write: addr 0x00, be 3. Data matches a zero-gap run.
- Zero length, plus start while busy: start with length 0 -> done in cycle 1 and no wren. A second start pulsed mid-RUN -> ignored; byte count and addresses unchanged.
- Reset mid-operation: reset after 2 of 4 bytes of an aligned transfer -> all outputs 0 asynchronously and no wren. A following transfer at base 0x010 writes addr 0x04 correctly.
- Full-size fill: base 0x000, length 1024, incrementing bytes -> 256 writes with be F, data {4k+3,4k+2,4k+1,4k} at addr k; done after the last write; 1024 bytes accepted in 1024 consecutive cycles.
